move_issuer: RTL
================

Name: move_issuer

Overview:
- Game-side initiator for the move checker: picks a pseudo-random move, pulses `start` with a one-hot `move` and a `play_freq` response window, then waits for the checker's `ready`/`correct` verdict.
- Keeps score, shortens the response window after each correct round, and ends the game on the first miss.
- Sits between the top-level game FSM/display and `check_move`.

Parameters:
- FREQ_INIT, 29'd100_000_000, response window of round 1 in clk cycles (1 s at 100 MHz).
- FREQ_STEP, 29'd5_000_000, window decrement per correct round.
- FREQ_MIN, 29'd25_000_000, floor of the window.
- GAP_CYCLES, 29'd50_000_000, idle cycles between a verdict and the next `start`.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- game_start  in  1  one-cycle request to begin or restart a game.
- ready  in  1  checker verdict valid (level); `correct` is meaningful while high.
- correct  in  1  checker verdict, 1 = player matched the move.
- start  out  1  one-cycle pulse to the checker.
- move  out  13  one-hot move; bits 4:0 = btn[4:0], bits 12:5 = sw[7:0]; held stable from `start` until the next issue.
- play_freq  out  29  current response window; stable while `busy`.
- score  out  8  correct rounds this game, saturating at 255.
- busy  out  1  high in ISSUE/WAIT/GAP.
- game_over  out  1  high in OVER.

Behaviour:
- Reset values (asynchronous): start=0, move=0, play_freq=FREQ_INIT, score=0, busy=0, game_over=0, lfsr=LFSR_SEED, gap counter=0, state=IDLE.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, advances every clk cycle in every state.
- Move index: idx = lfsr[3:0]; if idx>=13 then idx-=13.
- IDLE: outputs quiet. On game_start: score<=0, play_freq<=FREQ_INIT, go to ISSUE.
- ISSUE: lasts exactly 1 cycle.
  - Registers move<=1<<idx.
  - start=1 in this cycle; `move` is already valid in the same cycle.
  - Next state is WAIT.
- WAIT:
  - The first WAIT cycle ignores `ready`; the checker drops it within one cycle of `start`.
  - From the 2nd cycle on, the first cycle with ready=1 is consumed.
    - correct=1: score<=sat(score+1); play_freq<=(play_freq>=FREQ_MIN+FREQ_STEP)?play_freq-FREQ_STEP:FREQ_MIN; go to GAP.
    - correct=0: go to OVER; score and play_freq hold.
  - No internal timeout; the checker owns the window.
- GAP:
  - The counter counts 0..GAP_CYCLES-1, then goes to ISSUE.
  - GAP_CYCLES=0 behaves as 1.
- OVER: game_over=1, score held. On game_start, act as in IDLE: clear score, reload FREQ_INIT, go to ISSUE, and drop game_over the same cycle.
- game_start in ISSUE/WAIT/GAP is ignored.
- Simultaneous game_start and ready have no interaction, since they are only honoured in disjoint states.
- Reset mid-round returns everything to reset values immediately; a pending checker verdict is discarded.

Optional Feature:
- Macro: MOVE_NO_REPEAT_EN.
- Defined: if the computed idx equals the previous round's idx, use (idx+1) mod 13. Two consecutive moves within a game are then never equal. The previous idx is cleared to "none" on game_start.
- Undefined: idx is used as-is; repeats are allowed.

Decomposition:
- Shared package (game_pkg):
  - Constants: MOVE_W=13, FREQ_W=29, NUM_MOVES=13, SCORE_W=8.
  - State enum: IDLE, ISSUE, WAIT, GAP, OVER.
  - Move-bit constants: BTN0..BTN4, SW0..SW7.
- Sub-module: move_lfsr (16-bit LFSR plus mod-13 index output).
- The FSM, score and window arithmetic stay in move_issuer.

Test Plan (sim params: FREQ_INIT=20, FREQ_STEP=4, FREQ_MIN=8, GAP_CYCLES=3, seed 16'hACE1):
1. Reset, then game_start pulse -> start pulses exactly 1 cycle, 2 clks later. move is one-hot and matches the model LFSR idx. play_freq=20, busy=1.
2. Hold ready=1 through the first WAIT cycle, correct=1 on the 2nd -> only the 2nd cycle is consumed. score=1, play_freq=16. Next start comes 3 GAP cycles later.
3. Five consecutive correct rounds -> play_freq goes 16,12,8,8,8 (clamped at FREQ_MIN); score=5.
4. Verdict ready=1, correct=0 -> game_over=1, busy=0, score holds. A later game_start -> score=0, play_freq=20, new start issued.
5. Assert rst_n=0 during WAIT -> all outputs return to reset values asynchronously. game_start during WAIT/GAP is ignored (no extra start).
6. With MOVE_NO_REPEAT_EN defined, 200 rounds -> no two consecutive moves equal. With it undefined, repeats occur at the model-predicted rounds.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared constants, state encoding and move bits for the move game
package game_pkg;

  localparam int MOVE_W    = 13;
  localparam int FREQ_W    = 29;
  localparam int NUM_MOVES = 13;
  localparam int SCORE_W   = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    GAP,
    OVER
  } state_t;

  // Bits 4:0 map to the push buttons, bits 12:5 to the slide switches.
  localparam logic [MOVE_W-1:0] BTN0 = 13'h0001;
  localparam logic [MOVE_W-1:0] BTN1 = 13'h0002;
  localparam logic [MOVE_W-1:0] BTN2 = 13'h0004;
  localparam logic [MOVE_W-1:0] BTN3 = 13'h0008;
  localparam logic [MOVE_W-1:0] BTN4 = 13'h0010;
  localparam logic [MOVE_W-1:0] SW0  = 13'h0020;
  localparam logic [MOVE_W-1:0] SW1  = 13'h0040;
  localparam logic [MOVE_W-1:0] SW2  = 13'h0080;
  localparam logic [MOVE_W-1:0] SW3  = 13'h0100;
  localparam logic [MOVE_W-1:0] SW4  = 13'h0200;
  localparam logic [MOVE_W-1:0] SW5  = 13'h0400;
  localparam logic [MOVE_W-1:0] SW6  = 13'h0800;
  localparam logic [MOVE_W-1:0] SW7  = 13'h1000;

endpackage

// File: rtl/move_lfsr.sv
// rtl/move_lfsr.sv - free-running 16-bit Fibonacci LFSR with a mod-13 move index
module move_lfsr
  import game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] idx
);

  logic [15:0] r_lfsr;
  logic        w_fb;
  logic [3:0]  w_low;

  // Taps for x^16+x^14+x^13+x^11+1 in right-shifting form.
  assign w_fb  = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
  assign w_low = r_lfsr[3:0];
  assign idx   = (w_low >= 4'(NUM_MOVES)) ? w_low - 4'(NUM_MOVES) : w_low;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= {w_fb, r_lfsr[15:1]};
    end
  end

endmodule

// File: rtl/move_issuer.sv
// rtl/move_issuer.sv - issues random one-hot moves to the checker, keeps score and window
// Optional MOVE_NO_REPEAT_EN: forbids the same move twice in a row within a game.
module move_issuer
  import game_pkg::*;
#(
  parameter logic [FREQ_W-1:0] FREQ_INIT  = 29'd100_000_000,
  parameter logic [FREQ_W-1:0] FREQ_STEP  = 29'd5_000_000,
  parameter logic [FREQ_W-1:0] FREQ_MIN   = 29'd25_000_000,
  parameter logic [FREQ_W-1:0] GAP_CYCLES = 29'd50_000_000,
  parameter logic [15:0]       LFSR_SEED  = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               game_start,
  input  logic               ready,
  input  logic               correct,
  output logic               start,
  output logic [MOVE_W-1:0]  move,
  output logic [FREQ_W-1:0]  play_freq,
  output logic [SCORE_W-1:0] score,
  output logic               busy,
  output logic               game_over
);

  localparam logic [FREQ_W-1:0] GAP_LAST =
    (GAP_CYCLES == '0) ? '0 : GAP_CYCLES - 29'd1;

  state_t             r_state, w_next;
  logic [3:0]         w_idx_raw, w_idx;
  logic [MOVE_W-1:0]  r_move;
  logic [FREQ_W-1:0]  r_freq, r_gap_cnt;
  logic [SCORE_W-1:0] r_score;
  logic               r_first_wait;
  logic               w_new_game, w_verdict, w_enter_issue;

  move_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .idx   (w_idx_raw)
  );

  always_comb begin
    w_next     = r_state;
    w_new_game = 1'b0;
    w_verdict  = 1'b0;
    case (r_state)
      IDLE, OVER: begin
        if (game_start) begin
          w_next     = ISSUE;
          w_new_game = 1'b1;
        end
      end
      ISSUE: w_next = WAIT;
      WAIT: begin
        // The checker may still show the previous verdict in the first WAIT cycle.
        if (ready && !r_first_wait) begin
          w_verdict = 1'b1;
          w_next    = correct ? GAP : OVER;
        end
      end
      GAP: begin
        if (r_gap_cnt == GAP_LAST) w_next = ISSUE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_enter_issue = (w_next == ISSUE);

`ifdef MOVE_NO_REPEAT_EN
  logic [3:0] r_prev_idx;
  logic       r_prev_vld;
  logic       w_repeat;

  assign w_repeat = r_prev_vld && !w_new_game && (w_idx_raw == r_prev_idx);
  assign w_idx    = !w_repeat ? w_idx_raw :
                    (w_idx_raw == 4'(NUM_MOVES - 1)) ? 4'd0 : w_idx_raw + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_idx <= '0;
      r_prev_vld <= 1'b0;
    end else if (w_enter_issue) begin
      r_prev_idx <= w_idx;
      r_prev_vld <= 1'b1;
    end
  end
`else
  assign w_idx = w_idx_raw;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_move       <= '0;
      r_freq       <= FREQ_INIT;
      r_score      <= '0;
      r_gap_cnt    <= '0;
      r_first_wait <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_first_wait <= (r_state == ISSUE);
      r_gap_cnt    <= (r_state == GAP && w_next == GAP) ? r_gap_cnt + 29'd1 : '0;
      if (w_enter_issue) r_move <= MOVE_W'(1) << w_idx;
      if (w_new_game) begin
        r_score <= '0;
        r_freq  <= FREQ_INIT;
      end else if (w_verdict && correct) begin
        r_score <= (r_score == '1) ? r_score : r_score + 8'd1;
        r_freq  <= (r_freq >= FREQ_MIN + FREQ_STEP) ? r_freq - FREQ_STEP : FREQ_MIN;
      end
    end
  end

  assign start     = (r_state == ISSUE);
  assign move      = r_move;
  assign play_freq = r_freq;
  assign score     = r_score;
  assign busy      = (r_state == ISSUE) || (r_state == WAIT) || (r_state == GAP);
  assign game_over = (r_state == OVER);

endmodule
